apb_slave_regfile: RTL and testbench

//   APB completer sitting directly downstream of the team's APB master: decodes PSEL/PENABLE

---
 rtl/apb_slave_regfile_pkg.sv | 15 +
 rtl/apb_slave_regfile_if.sv | 24 ++
 rtl/apb_slave_regfile_reg_bank.sv | 53 +++++
 rtl/apb_slave_regfile.sv | 122 ++++++++++++
 tb/tb_apb_slave_regfile.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_regfile_pkg.sv
// Shared APB definitions: bus widths, word addressing and the completer FSM states.
// The team's APB master uses the same definitions.
package apb_slave_regfile_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } apb_state_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the master and the register-file completer.
interface apb_slave_regfile_if;
    import apb_slave_regfile_pkg::*;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_ADDR_W-1:0] PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_regfile_reg_bank.sv
// Word register storage with address decode, error detection and a read-only ID word
// in the top slot.
module apb_slave_regfile_reg_bank
    import apb_slave_regfile_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [APB_DATA_W-1:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [APB_ADDR_W-1:0] addr,
    input  logic                  write,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic                  commit,
    output logic [APB_DATA_W-1:0] rdata,
    output logic                  err
);

    localparam int                    IDX_W      = $clog2(NUM_REGS);
    localparam logic [APB_ADDR_W-1:0] NUM_REGS_A = APB_ADDR_W'(NUM_REGS);
    localparam logic [IDX_W-1:0]      ID_IDX     = IDX_W'(NUM_REGS - 1);

    logic [APB_ADDR_W-1:0] offset;
    logic [APB_ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]      sel;
    logic                  in_range;
    logic                  is_id;
    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        offset   = addr - BASE_ADDR;
        word_idx = offset >> WORD_SHIFT;
        sel      = word_idx[IDX_W-1:0];
        in_range = (word_idx < NUM_REGS_A);
        is_id    = (sel == ID_IDX);
        err      = (addr[WORD_SHIFT-1:0] != '0) || !in_range || (write && is_id);
        rdata    = err ? '0 : (is_id ? ID_VALUE : regs[sel]);
    end

    // The ID slot flags a write error, so its storage word is never loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && write && !err) begin
            regs[sel] <= wdata;
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: access FSM with programmable wait states in front of a word register bank.
// PREADY, PSLVERR and PRDATA are all registered.
module apb_slave_regfile
    import apb_slave_regfile_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_slave_regfile_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    apb_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  start;
    logic                  enter_done;

    logic [APB_ADDR_W-1:0] addr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic                  write_q;
    logic [APB_ADDR_W-1:0] req_addr;
    logic [APB_DATA_W-1:0] req_wdata;
    logic                  req_write;

    logic [APB_DATA_W-1:0] bank_rdata;
    logic                  bank_err;
    logic [APB_DATA_W-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;

    assign start = (state_q == IDLE) && bus.PSEL && bus.PENABLE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Losing PSEL mid-wait abandons the transfer without a response.
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait transfers complete on the sampling edge, so the bank sees the live bus in IDLE.
    always_comb begin
        req_addr  = (state_q == IDLE) ? bus.PADDR  : addr_q;
        req_wdata = (state_q == IDLE) ? bus.PWDATA : wdata_q;
        req_write = (state_q == IDLE) ? bus.PWRITE : write_q;
    end

    always_ff @(posedge PCLK) begin
        if (start) begin
            addr_q  <= bus.PADDR;
            wdata_q <= bus.PWDATA;
            write_q <= bus.PWRITE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= enter_done;
            pslverr_q <= enter_done && bank_err;
            if (enter_done && !req_write) begin
                prdata_q <= bank_rdata;
            end
        end
    end

    apb_slave_regfile_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .ID_VALUE  (ID_VALUE)
    ) u_reg_bank (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .addr   (req_addr),
        .write  (req_write),
        .wdata  (req_wdata),
        .commit (enter_done),
        .rdata  (bank_rdata),
        .err    (bank_err)
    );

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (1, 0 and 3 wait states) driven by directed
// APB transfers and checked every cycle against a transaction-level model.
module tb_apb_slave_regfile;

    localparam int          ND   = 3;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] IDV  = 32'hA9B0_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel   [ND];
    logic        pen    [ND];
    logic        pwr    [ND];
    logic [31:0] paddr  [ND];
    logic [31:0] pwdata [ND];
    logic [31:0] prdata [ND];
    logic        pready [ND];
    logic        pslverr[ND];

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_slave_regfile_if u_bus ();
        assign u_bus.PSEL    = psel[g];
        assign u_bus.PENABLE = pen[g];
        assign u_bus.PWRITE  = pwr[g];
        assign u_bus.PADDR   = paddr[g];
        assign u_bus.PWDATA  = pwdata[g];
        assign prdata[g]     = u_bus.PRDATA;
        assign pready[g]     = u_bus.PREADY;
        assign pslverr[g]    = u_bus.PSLVERR;

        apb_slave_regfile #(
            .NUM_REGS    (NR),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .ID_VALUE    (IDV)
        ) u_dut (
            .PCLK    (clk),
            .PRESETn (rst_n),
            .bus     (u_bus)
        );
    end

    function automatic int wc_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // Transaction model: a transfer accepted at one edge completes wc_of(k) edges later,
    // and the edge after a completion never accepts a new transfer.
    logic [31:0] m_mem  [ND][NR];
    bit          m_busy [ND];
    bit          m_hold [ND];
    bit          m_rdy  [ND];
    bit          m_err  [ND];
    int          m_due  [ND];
    bit          m_w    [ND];
    logic [31:0] m_a    [ND];
    logic [31:0] m_d    [ND];
    logic [31:0] m_rdata[ND];

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            for (int r = 0; r < NR; r++) m_mem[k][r] = '0;
            m_busy[k] = 0; m_hold[k] = 0; m_rdy[k] = 0; m_err[k] = 0;
            m_due[k] = 0; m_rdata[k] = '0;
        end
    endtask

    task automatic model_complete(int k);
        logic [31:0] idx;
        bit          e;
        idx = (m_a[k] - BASE) >> 2;
        e = (m_a[k][1:0] != 2'b00) || (idx >= 32'(NR)) || (m_w[k] && idx == 32'(NR - 1));
        if (m_w[k]) begin
            if (!e) m_mem[k][idx[3:0]] = m_d[k];
        end else begin
            m_rdata[k] = e ? 32'h0 : ((idx == 32'(NR - 1)) ? IDV : m_mem[k][idx[3:0]]);
        end
        m_err[k]  = e;
        m_rdy[k]  = 1;
        m_busy[k] = 0;
        m_hold[k] = 1;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        for (int k = 0; k < ND; k++) begin
            m_rdy[k] = 0;
            m_err[k] = 0;
            if (m_hold[k]) begin
                m_hold[k] = 0;
            end else if (m_busy[k] && !psel[k]) begin
                m_busy[k] = 0;
            end else if (!m_busy[k] && psel[k] && pen[k]) begin
                m_busy[k] = 1;
                m_due[k]  = cyc + wc_of(k);
                m_w[k] = pwr[k]; m_a[k] = paddr[k]; m_d[k] = pwdata[k];
            end
            if (m_busy[k] && cyc == m_due[k]) model_complete(k);
        end
    endtask

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h, expected %h", nm, k, act, exp);
    endtask

    task automatic compare_all();
        for (int k = 0; k < ND; k++) begin
            if (!rst_n) begin
                chk("rst_pready", k, 32'(pready[k]), 32'h0);
                chk("rst_pslverr", k, 32'(pslverr[k]), 32'h0);
                chk("rst_prdata", k, prdata[k], 32'h0);
            end else begin
                chk("pready", k, 32'(pready[k]), 32'(m_rdy[k]));
                chk("pslverr", k, 32'(pslverr[k]), 32'(m_err[k]));
                chk("prdata", k, prdata[k], m_rdata[k]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic xfer(int k, bit w, logic [31:0] a, logic [31:0] d, bit setup,
                        output logic [31:0] rd, output logic [31:0] er, output int lat);
        bit got;
        pwr[k] = w; paddr[k] = a; pwdata[k] = d;
        if (setup) begin
            psel[k] = 1; pen[k] = 0;
            tick();
        end
        psel[k] = 1; pen[k] = 1;
        got = 0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (pready[k]) got = 1;
        end
        rd = prdata[k];
        er = 32'(pslverr[k]);
        psel[k] = 0; pen[k] = 0;
        if (!got) chk("xfer_timeout", k, 32'(got), 32'h1);
        tick();
        chk("pulse_width", k, 32'(pready[k]), 32'h0);
    endtask

    task automatic b2b();
        bit          got;
        bit          w;
        logic [31:0] a;
        int          prev_c;
        prev_c = 0;
        psel[0] = 1; pen[0] = 1;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4);
            a = w ? (32'h20 + 32'(4 * i)) : (32'h2C - 32'(4 * (i - 4)));
            pwr[0] = w; paddr[0] = a; pwdata[0] = 32'hB0B0_0000 + 32'(i);
            got = 0;
            for (int j = 0; j < 20 && !got; j++) begin
                tick();
                if (pready[0]) got = 1;
            end
            if (!got) chk("b2b_timeout", 0, 32'(got), 32'h1);
            if (i > 0) chk("b2b_gap", 0, 32'(cyc - prev_c), 32'd3);
            prev_c = cyc;
            if (!w) chk("b2b_rdata", 0, prdata[0], 32'hB0B0_0000 + 32'(7 - i));
            chk("b2b_err", 0, 32'(pslverr[0]), 32'h0);
        end
        psel[0] = 0; pen[0] = 0;
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] rd, er;
        int          lat;
        bit          got;

        for (int k = 0; k < ND; k++) begin
            psel[k] = 0; pen[k] = 0; pwr[k] = 0; paddr[k] = '0; pwdata[k] = '0;
        end
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_prdata", 0, prdata[0], 32'h0);
        chk("reset_pready", 0, 32'(pready[0]), 32'h0);

        // Reset asserted while a write to 0x04 waits on dut0
        psel[0] = 1; pen[0] = 1; pwr[0] = 1; paddr[0] = 32'h04; pwdata[0] = 32'h1234;
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midwait_rst_pready", 0, 32'(pready[0]), 32'h0);
        chk("midwait_rst_prdata", 0, prdata[0], 32'h0);
        psel[0] = 0; pen[0] = 0; pwr[0] = 0;
        tick();
        rst_n = 1'b1;
        tick();
        xfer(0, 0, 32'h04, 32'h0, 0, rd, er, lat);
        chk("rd04_after_rst", 0, rd, 32'h0);

        // One wait state
        xfer(0, 1, 32'h08, 32'hDEADBEEF, 0, rd, er, lat);
        chk("wr08_lat", 0, 32'(lat), 32'd2);
        chk("wr08_err", 0, er, 32'h0);
        xfer(0, 0, 32'h08, 32'h0, 1, rd, er, lat);
        chk("rd08_data", 0, rd, 32'hDEADBEEF);
        chk("rd08_lat", 0, 32'(lat), 32'd2);

        // Zero and three wait states
        xfer(1, 1, 32'h10, 32'h0000_0011, 0, rd, er, lat);
        chk("wc0_wr_lat", 1, 32'(lat), 32'd1);
        xfer(1, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("wc0_rd_lat", 1, 32'(lat), 32'd1);
        chk("wc0_rd_data", 1, rd, 32'h0000_0011);
        xfer(2, 1, 32'h38, 32'h3333_3333, 0, rd, er, lat);
        chk("wc3_wr_lat", 2, 32'(lat), 32'd4);
        xfer(2, 0, 32'h38, 32'h0, 1, rd, er, lat);
        chk("wc3_rd_lat", 2, 32'(lat), 32'd4);
        chk("wc3_rd_data", 2, rd, 32'h3333_3333);

        // Error decode and the ID word
        xfer(0, 0, 32'h06, 32'h0, 0, rd, er, lat);
        chk("rd06_err", 0, er, 32'h1);
        chk("rd06_data", 0, rd, 32'h0);
        xfer(0, 0, 32'h08, 32'h0, 0, rd, er, lat);
        chk("rd08_again", 0, rd, 32'hDEADBEEF);
        xfer(0, 0, 32'h40, 32'h0, 0, rd, er, lat);
        chk("rd40_err", 0, er, 32'h1);
        chk("rd40_data", 0, rd, 32'h0);
        xfer(0, 0, 32'hFFFF_FFFC, 32'h0, 0, rd, er, lat);
        chk("rd_wrap_err", 0, er, 32'h1);
        xfer(0, 1, 32'h3C, 32'h1111_2222, 0, rd, er, lat);
        chk("wr3c_err", 0, er, 32'h1);
        xfer(0, 0, 32'h3C, 32'h0, 0, rd, er, lat);
        chk("rd3c_err", 0, er, 32'h0);
        chk("rd3c_id", 0, rd, IDV);

        // Abort: PSEL dropped during the wait state
        xfer(0, 1, 32'h0C, 32'h0000_0077, 0, rd, er, lat);
        psel[0] = 1; pen[0] = 1; pwr[0] = 1; paddr[0] = 32'h0C; pwdata[0] = 32'h55;
        tick();
        psel[0] = 0; pen[0] = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_pready", 0, 32'(pready[0]), 32'h0);
        end
        xfer(0, 0, 32'h0C, 32'h0, 0, rd, er, lat);
        chk("rd0c_after_abort", 0, rd, 32'h0000_0077);

        // Bus changes during the wait states must not affect the latched request
        psel[2] = 1; pen[2] = 1; pwr[2] = 1; paddr[2] = 32'h14; pwdata[2] = 32'hCAFE;
        tick();
        paddr[2] = 32'h18; pwr[2] = 0; pwdata[2] = 32'h0;
        got = 0; lat = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (pready[2]) got = 1;
        end
        chk("latch_lat", 2, 32'(lat), 32'd4);
        psel[2] = 0; pen[2] = 0;
        tick();
        xfer(2, 0, 32'h14, 32'h0, 0, rd, er, lat);
        chk("rd14_latched", 2, rd, 32'h0000_CAFE);
        xfer(2, 0, 32'h18, 32'h0, 0, rd, er, lat);
        chk("rd18_untouched", 2, rd, 32'h0);

        b2b();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
